// File: rtl/simple_task.sv
// -----------------------------------------------------------------------------
// simple_task
//
// Registered 8-bit temperature converter. By default it converts Celsius to
// Fahrenheit. When mode is high it converts Fahrenheit to Celsius. Results
// are rounded to the nearest integer and clamped to the output range.
// Latency is one clock. A new sample can be accepted every cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears all outputs)
//   in_valid   temp_in/mode are sampled on a clk edge while high
//   mode       0 = C->F, 1 = F->C
//   temp_in    unsigned input temperature [WIDTH]
//   temp_out   unsigned converted temperature, registered [WIDTH]
//   out_valid  high for exactly the cycle after an accepted input
//   sat        high when the registered result was clamped (held while idle)
// -----------------------------------------------------------------------------
module simple_task #(
  parameter int WIDTH    = 8,
  parameter int F_OFFSET = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] temp_in,
  output logic [WIDTH-1:0] temp_out,
  output logic             out_valid,
  output logic             sat
);

  // Intermediate width: 9*255+2 = 2297 needs 12 bits.
  localparam int IW = WIDTH + 4;
  // Width of the reciprocal-multiply product (16 fractional bits).
  localparam int MW = IW + 16;
  localparam logic [IW-1:0] MAXV = IW'((1 << WIDTH) - 1);
  localparam logic [IW-1:0] OFFS = IW'(F_OFFSET);

  // floor(n/5) for n <= 2297. 13108/65536 exceeds 1/5 by less than 0.03/n
  // over that range, and the fraction of n/5 is at most 0.8. The truncated
  // product therefore never crosses into the next integer.
  function automatic logic [IW-1:0] div5(input logic [IW-1:0] n);
    logic [MW-1:0] p;
    p = {16'b0, n} * MW'(13108);
    return IW'(p >> 16);
  endfunction

  // floor(n/9) for n <= 1119. 7282/65536 exceeds 1/9 by about 3.4e-6, so the
  // error stays below 0.004 against a worst-case fraction of 8/9.
  function automatic logic [IW-1:0] div9(input logic [IW-1:0] n);
    logic [MW-1:0] p;
    p = {16'b0, n} * MW'(7282);
    return IW'(p >> 16);
  endfunction

  // Clamp to the output range. The result is {sat, value}.
  function automatic logic [WIDTH:0] sat_clamp(input logic [IW-1:0] raw);
    if (raw > MAXV) return {1'b1, {WIDTH{1'b1}}};
    else            return {1'b0, raw[WIDTH-1:0]};
  endfunction

  // C->F: round(9c/5) + offset. Adding 2 before /5 gives round-to-nearest.
  function automatic logic [WIDTH:0] c2f(input logic [WIDTH-1:0] t);
    logic [IW-1:0] num;
    num = {{(IW-WIDTH){1'b0}}, t} * IW'(9) + IW'(2);
    return sat_clamp(div5(num) + OFFS);
  endfunction

  // F->C: round(5(f-offset)/9). Adding 4 before /9 gives round-to-nearest.
  // Inputs below the offset would be negative, so they clamp to zero.
  function automatic logic [WIDTH:0] f2c(input logic [WIDTH-1:0] t);
    logic [IW-1:0] ext;
    logic [IW-1:0] num;
    ext = {{(IW-WIDTH){1'b0}}, t};
    if (ext < OFFS) return {1'b1, {WIDTH{1'b0}}};
    num = (ext - OFFS) * IW'(5) + IW'(4);
    return sat_clamp(div9(num));
  endfunction

  logic [WIDTH:0]   res;
  logic [WIDTH-1:0] temp_d, temp_q;
  logic             sat_d, sat_q;
  logic             vld_d, vld_q;

  always_comb begin
    res    = mode ? f2c(temp_in) : c2f(temp_in);
    temp_d = temp_q;
    sat_d  = sat_q;
    vld_d  = in_valid;
    if (in_valid) begin
      temp_d = res[WIDTH-1:0];
      sat_d  = res[WIDTH];
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_q <= '0;
      sat_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      temp_q <= temp_d;
      sat_q  <= sat_d;
      vld_q  <= vld_d;
    end
  end

  assign temp_out  = temp_q;
  assign sat       = sat_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_simple_task.sv
module tb_simple_task;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] temp_in = 8'd0;
  logic [7:0] temp_out;
  logic       out_valid;
  logic       sat;

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;

  simple_task #(.WIDTH(8), .F_OFFSET(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .mode(mode),
    .temp_in(temp_in),
    .temp_out(temp_out),
    .out_valid(out_valid),
    .sat(sat)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic taken from the conversion rules.
  function automatic int exp_raw(input bit m, input int t);
    if (!m) return (9 * t + 2) / 5 + 32;
    else    return (t < 32) ? -1 : ((t - 32) * 5 + 4) / 9;
  endfunction

  function automatic int exp_temp(input bit m, input int t);
    int r;
    r = exp_raw(m, t);
    if (r > 255) return 255;
    if (r < 0)   return 0;
    return r;
  endfunction

  function automatic bit exp_sat(input bit m, input int t);
    int r;
    r = exp_raw(m, t);
    return (r > 255) || (r < 0);
  endfunction

  // The scoreboard holds the output state the spec requires.
  int m_t = 0;
  bit m_s = 1'b0;
  bit m_v = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0;
      m_s <= 1'b0;
      m_v <= 1'b0;
    end else begin
      m_v <= in_valid;
      if (in_valid) begin
        m_t <= exp_temp(mode, int'(temp_in));
        m_s <= exp_sat(mode, int'(temp_in));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Per-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_valid", int'(out_valid), int'(m_v));
      chk("mon_temp",  int'(temp_out),  m_t);
      chk("mon_sat",   int'(sat),       int'(m_s));
    end
  end

  // Called 1 time unit after a rising edge. Presents one input and then
  // checks the result one cycle later against a hand-computed value.
  task automatic apply(input bit m, input int t, input int et, input bit es,
                       input string nm);
    mode     = m;
    temp_in  = t[7:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "/valid"}, int'(out_valid), 1);
    chk({nm, "/temp"},  int'(temp_out),  et);
    chk({nm, "/sat"},   int'(sat),       int'(es));
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle();
    chk("rst/temp",  int'(temp_out),  0);
    chk("rst/valid", int'(out_valid), 0);
    chk("rst/sat",   int'(sat),       0);
    rst = 1'b0;
    idle();
    chk("post_rst/valid", int'(out_valid), 0);
    chk("post_rst/temp",  int'(temp_out),  0);

    // C->F sweep with one pulse per input
    for (int i = 0; i <= 10; i++) begin
      apply(1'b0, i * 10, 32 + 18 * i, 1'b0, "c2f_sweep");
      idle();
      chk("c2f_sweep/gap_valid", int'(out_valid), 0);
    end

    // C->F saturation boundary
    apply(1'b0, 124, 255, 1'b0, "c2f_124");
    apply(1'b0, 125, 255, 1'b1, "c2f_125");
    apply(1'b0, 255, 255, 1'b1, "c2f_255");

    // F->C
    apply(1'b1, 212, 100, 1'b0, "f2c_212");
    apply(1'b1, 50,  10,  1'b0, "f2c_50");
    apply(1'b1, 32,  0,   1'b0, "f2c_32");
    apply(1'b1, 31,  0,   1'b1, "f2c_31");
    apply(1'b1, 255, 124, 1'b0, "f2c_255");

    // Rounding
    apply(1'b0, 1,  34, 1'b0, "c2f_1");
    apply(1'b0, 3,  37, 1'b0, "c2f_3");
    apply(1'b1, 33, 1,  1'b0, "f2c_33");
    apply(1'b1, 34, 1,  1'b0, "f2c_34");

    // Streaming with alternating mode, then hold
    idle();
    apply(1'b0, 20,  68,  1'b0, "stream0");
    apply(1'b1, 212, 100, 1'b0, "stream1");
    apply(1'b0, 125, 255, 1'b1, "stream2");
    apply(1'b1, 31,  0,   1'b1, "stream3");
    apply(1'b0, 1,   34,  1'b0, "stream4");
    idle();
    chk("hold/valid", int'(out_valid), 0);
    chk("hold/temp",  int'(temp_out),  34);
    chk("hold/sat",   int'(sat),       0);

    // Saturated result followed by an idle cycle: sat must hold
    apply(1'b0, 200, 255, 1'b1, "sat_before_hold");
    idle();
    chk("sat_hold/valid", int'(out_valid), 0);
    chk("sat_hold/sat",   int'(sat),       1);
    apply(1'b0, 5, 41, 1'b0, "c2f_5");

    // Async reset between edges; an input presented during reset is dropped
    #3 rst = 1'b1;
    #1;
    chk("arst/temp",  int'(temp_out),  0);
    chk("arst/valid", int'(out_valid), 0);
    chk("arst/sat",   int'(sat),       0);
    mode = 1'b0; temp_in = 8'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("arst_in/valid", int'(out_valid), 0);
    #2 rst = 1'b0;
    idle();
    chk("arst_rel/valid", int'(out_valid), 0);
    chk("arst_rel/temp",  int'(temp_out),  0);

    // Back-to-back sweep of every input in both modes, checked by the model
    for (int m = 0; m < 2; m++) begin
      for (int t = 0; t < 256; t++) begin
        mode     = m[0];
        temp_in  = t[7:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    idle();
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
